// File: rtl/cordic_seq.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, arctan constants from an
// external combinational rom addressed by the iteration index. Returns cos/sin of i_theta.
module cordic_seq #(
  parameter int unsigned   ITERS = 24,
  parameter int unsigned   DW    = 26,
  parameter int unsigned   AW    = 5,
  parameter logic [DW-1:0] KINIT = 26'h09B74ED
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [DW-1:0] i_theta,
  output logic          o_busy,
  output logic          o_done,
  output logic [DW-1:0] o_cos,
  output logic [DW-1:0] o_sin,
  output logic [AW-1:0] o_rom_addr,
  input  logic [DW-1:0] i_rom_data
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // iter is one bit wider than the rom address so ITERS=32 reaches its last index cleanly
  localparam logic [AW:0] LastIter = (AW+1)'(ITERS - 1);

  state_e               r_state;
  logic [AW:0]          r_iter;
  logic signed [DW-1:0] r_x;
  logic signed [DW-1:0] r_y;
  logic signed [DW-1:0] r_z;
  logic [DW-1:0]        r_cos;
  logic [DW-1:0]        r_sin;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_dir;
  logic signed [DW-1:0] w_x_sh;
  logic signed [DW-1:0] w_y_sh;
  logic signed [DW-1:0] w_atan;
  logic signed [DW-1:0] w_x_nxt;
  logic signed [DW-1:0] w_y_nxt;
  logic signed [DW-1:0] w_z_nxt;

  always_comb begin
    w_dir   = ~r_z[DW-1];
    w_x_sh  = r_x >>> r_iter;
    w_y_sh  = r_y >>> r_iter;
    w_atan  = $signed(i_rom_data);
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    w_z_nxt = r_z;
    // Rotate toward z = 0; all sums wrap at DW bits
    if (w_dir) begin
      w_x_nxt = r_x - w_y_sh;
      w_y_nxt = r_y + w_x_sh;
      w_z_nxt = r_z - w_atan;
    end else begin
      w_x_nxt = r_x + w_y_sh;
      w_y_nxt = r_y - w_x_sh;
      w_z_nxt = r_z + w_atan;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_iter  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_cos   <= '0;
      r_sin   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_x     <= KINIT;
            r_y     <= '0;
            r_z     <= i_theta;
            r_iter  <= '0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_x    <= w_x_nxt;
          r_y    <= w_y_nxt;
          r_z    <= w_z_nxt;
          r_iter <= r_iter + 1'b1;
          if (r_iter == LastIter) begin
            r_cos   <= w_x_nxt;
            r_sin   <= w_y_nxt;
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_cos      = r_cos;
  assign o_sin      = r_sin;
  assign o_rom_addr = (r_state == StRun) ? r_iter[AW-1:0] : '0;

endmodule

// File: tb/tb_cordic_seq.sv
// Self-checking bench for cordic_seq: arctan rom model, scoreboard of expected cos/sin,
// directed angles, back-to-back starts, and an asynchronous reset in mid-run.
module tb_cordic_seq;

  localparam int ITERS = 24;
  localparam int TOL   = 16;
  localparam logic signed [25:0] KINIT = 26'sh09B74ED;

  typedef struct {
    logic signed [25:0] c;
    logic signed [25:0] s;
    int                 rc;
    int                 rs;
    bit                 has_ref;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic signed [25:0] theta;
  logic busy;
  logic done;
  logic signed [25:0] cos_o;
  logic signed [25:0] sin_o;
  logic [4:0] rom_addr;
  logic signed [25:0] rom_data;

  logic signed [25:0] rom [32];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic signed [25:0] hold_cos;
  logic signed [25:0] hold_sin;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  cordic_seq dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_theta    (theta),
    .o_busy     (busy),
    .o_done     (done),
    .o_cos      (cos_o),
    .o_sin      (sin_o),
    .o_rom_addr (rom_addr),
    .i_rom_data (rom_data)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic signed [25:0] obs, input int ref_val);
    int  diff;
    logic ok;
    diff = int'(obs) - ref_val;
    ok = !$isunknown(obs) && (diff <= TOL) && (diff >= -TOL);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, ref_val, TOL);
    end
  endtask

  // Bit-exact rotation-mode CORDIC over the bench's own rom table
  task automatic model(input logic signed [25:0] th, output logic signed [25:0] c,
                       output logic signed [25:0] s);
    logic signed [25:0] x, y, z, xn;
    x = KINIT;
    y = '0;
    z = th;
    for (int i = 0; i < ITERS; i++) begin
      if (!z[25]) begin
        xn = x - (y >>> i);
        y  = y + (x >>> i);
        z  = z - rom[i];
      end else begin
        xn = x + (y >>> i);
        y  = y - (x >>> i);
        z  = z + rom[i];
      end
      x = xn;
    end
    c = x;
    s = y;
  endtask

  task automatic push_exp(input logic signed [25:0] th, input bit has_ref, input int rc,
                          input int rs);
    exp_t e;
    logic signed [25:0] c, s;
    model(th, c, s);
    e.c = c;
    e.s = s;
    e.rc = rc;
    e.rs = rs;
    e.has_ref = has_ref;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_cos"}, 32'(cos_o), 32'(e.c));
      chk({tag, "_sin"}, 32'(sin_o), 32'(e.s));
      if (e.has_ref) begin
        chk_tol({tag, "_cos_ref"}, cos_o, e.rc);
        chk_tol({tag, "_sin_ref"}, sin_o, e.rs);
      end
      hold_cos = e.c;
      hold_sin = e.s;
    end
  endtask

  // One operation from IDLE: rom address walk, exact done latency, held outputs
  task automatic run_op(input logic signed [25:0] th, input bit has_ref, input int rc,
                        input int rs, input string tag);
    @(negedge clk);
    start = 1'b1;
    theta = th;
    push_exp(th, has_ref, rc, rs);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    theta = 26'($urandom);
    for (int n = 0; n <= ITERS + 1; n++) begin
      if (n > 0) @(negedge clk);
      if (n < ITERS) begin
        chk({tag, "_addr"}, 32'(rom_addr), n);
        chk({tag, "_busy_run"}, 32'(busy), 1);
        chk({tag, "_done_run"}, 32'(done), 0);
        chk({tag, "_cos_hold"}, 32'(cos_o), 32'(hold_cos));
        start = (n == 5);
      end else if (n == ITERS) begin
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_busy_done"}, 32'(busy), 1);
        chk({tag, "_addr_done"}, 32'(rom_addr), 0);
        pop_check(tag);
      end else begin
        chk({tag, "_done_end"}, 32'(done), 0);
        chk({tag, "_busy_end"}, 32'(busy), 0);
        chk({tag, "_addr_idle"}, 32'(rom_addr), 0);
        chk({tag, "_sin_held"}, 32'(sin_o), 32'(hold_sin));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rom[i] = 26'($rtoi($atan(1.0 / (2.0 ** i)) * 16777216.0 + 0.5));
    end
    rst_n = 1'b0;
    start = 1'b0;
    theta = '0;
    hold_cos = '0;
    hold_sin = '0;

    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cos", 32'(cos_o), 0);
    chk("rst_sin", 32'(sin_o), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    run_op(26'sd0, 1'b1, 16777216, 0, "zero");
    run_op(26'sd13176795, 1'b1, 11863283, 11863283, "pi4");
    run_op(-26'sd8784530, 1'b1, 14529495, -8388608, "mpi6");
    run_op(26'sd26353589, 1'b1, 0, 16777216, "pi2");
    run_op(-26'sd26353589, 1'b1, 0, -16777216, "mpi2");
    run_op(26'sh1FFFFFF, 1'b0, 0, 0, "outdom");

    // start held high: one-cycle done every ITERS+2 cycles, theta sampled only at acceptance
    @(negedge clk);
    start = 1'b1;
    theta = 26'sd4000000;
    push_exp(26'sd4000000, 1'b0, 0, 0);
    for (int k = 0; k < 78; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("held_done", 32'(done), 32'((k % 26) == 24));
      chk("held_busy", 32'(busy), 32'((k % 26) != 25));
      if ((k % 26) == 24) pop_check("held");
      if ((k % 26) == 10) theta = 26'($urandom);
      if (k == 25) begin
        theta = -26'sd12000000;
        push_exp(-26'sd12000000, 1'b0, 0, 0);
      end
      if (k == 51) begin
        theta = 26'sd9000000;
        push_exp(26'sd9000000, 1'b0, 0, 0);
      end
      if (k == 76) start = 1'b0;
    end
    chk("held_sb_empty", sb.size(), 0);

    // Asynchronous reset at iteration 10
    @(negedge clk);
    start = 1'b1;
    theta = 26'sd13176795;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_addr", 32'(rom_addr), 10);
    chk("mid_cos_hold", 32'(cos_o), 32'(hold_cos));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_cos", 32'(cos_o), 0);
    chk("arst_sin", 32'(sin_o), 0);
    chk("arst_addr", 32'(rom_addr), 0);
    hold_cos = '0;
    hold_sin = '0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);

    run_op(-26'sd8784530, 1'b1, 14529495, -8388608, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
